// File: rtl/mdu_param_if.sv
// ============================================================================
// Module      : mdu_param_if
// Description : Request/result bundle between the E stage and mdu_param.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdu_param_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [3:0]       Op;
   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] D2;
   logic             Flush;
   logic             Busy;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             DivZero;

   modport master (
      output Start, Op, D1, D2, Flush,
      input  Busy, HI, LO, DivZero
   );

   modport slave (
      input  Start, Op, D1, D2, Flush,
      output Busy, HI, LO, DivZero
   );
endinterface

`default_nettype wire

// File: rtl/mdu_param.sv
// ============================================================================
// Module      : mdu_param
// Description : Parametrised MIPS multiply/divide unit with HI/LO, MADD/MSUB,
//               fixed-latency Busy window and Flush cancellation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_param #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic     clk,
   input  wire logic     reset,
   mdu_param_if.slave    bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_dz_q, pend_dz_d;
   logic             dz_q, dz_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic               w_signed;
   logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_acc;
   logic               w_a_neg, w_b_neg, w_div_zero;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag, w_q, w_r;

   assign w_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) ||
                     (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);

   // Extending both operands to 2W bits lets one multiplier serve signed and unsigned forms.
   assign w_a_ext = {{WIDTH{w_signed & bus.D1[WIDTH-1]}}, bus.D1};
   assign w_b_ext = {{WIDTH{w_signed & bus.D2[WIDTH-1]}}, bus.D2};
   assign w_prod  = w_a_ext * w_b_ext;
   assign w_acc   = {hi_q, lo_q};

   assign w_a_neg    = w_signed & bus.D1[WIDTH-1];
   assign w_b_neg    = w_signed & bus.D2[WIDTH-1];
   assign w_a_mag    = w_a_neg ? (~bus.D1 + WIDTH'(1)) : bus.D1;
   assign w_b_mag    = w_b_neg ? (~bus.D2 + WIDTH'(1)) : bus.D2;
   assign w_div_zero = (bus.D2 == '0);
   assign w_b_div    = w_div_zero ? WIDTH'(1) : w_b_mag;
   assign w_q_mag    = w_a_mag / w_b_div;
   assign w_r_mag    = w_a_mag % w_b_div;
   // MIN/-1 wraps back to MIN through the magnitude path, remainder 0.
   assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
   assign w_r        = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;
      dz_d      = dz_q;
      cnt_d     = cnt_q;

      if (bus.Flush) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            if (pend_dz_q) begin
               dz_d = 1'b1;
            end else begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end
      end else if (bus.Start) begin
         unique case (bus.Op)
            OP_MULT, OP_MULTU: begin
               {pend_hi_d, pend_lo_d} = w_prod;
               pend_dz_d = 1'b0;
               cnt_d     = MULT_LOAD;
               dz_d      = 1'b0;
            end
            OP_MADD, OP_MADDU: begin
               {pend_hi_d, pend_lo_d} = w_acc + w_prod;
               pend_dz_d = 1'b0;
               cnt_d     = MULT_LOAD;
               dz_d      = 1'b0;
            end
            OP_MSUB, OP_MSUBU: begin
               {pend_hi_d, pend_lo_d} = w_acc - w_prod;
               pend_dz_d = 1'b0;
               cnt_d     = MULT_LOAD;
               dz_d      = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
               pend_hi_d = w_r;
               pend_lo_d = w_q;
               pend_dz_d = w_div_zero;
               cnt_d     = DIV_LOAD;
               dz_d      = 1'b0;
            end
            OP_MTHI: begin
               hi_d = bus.D1;
               dz_d = 1'b0;
            end
            OP_MTLO: begin
               lo_d = bus.D1;
               dz_d = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
         dz_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
         dz_q      <= dz_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.Busy    = (cnt_q != '0);
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign bus.DivZero = dz_q;

endmodule

`default_nettype wire
